// File: rtl/window_linebuffer.sv
// ---------------------------------------------------------------------------
// window_linebuffer
//
// Turns a raster-order pixel stream into WIN x WIN sliding windows for the
// hidden-layer inner-product bank. WIN-1 full image lines are kept in a line
// store. A WIN x WIN shift window moves one column per accepted pixel. Only
// windows that lie entirely inside one frame, with no row wrap inside them,
// are flagged valid.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   pix_valid  pix_data holds a pixel
//   pix_data   pixel, raster order (row-major, col 0 first)
//   pix_ready  block can accept pix_data this cycle
//   win_valid  win_data holds a complete window
//   win_data   WIN*WIN words; word k = i*WIN+j, i = row (0 = oldest), j = col
//   win_last   marks the final window of a frame
//   win_ready  consumer accepts win_data this cycle
// ---------------------------------------------------------------------------
module window_linebuffer #(
   parameter int DW    = 32,
   parameter int WIN   = 9,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   input  logic [DW-1:0]         pix_data,
   output logic                  pix_ready,
   output logic                  win_valid,
   output logic [WIN*WIN*DW-1:0] win_data,
   output logic                  win_last,
   input  logic                  win_ready
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(WIN - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(WIN - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   // line_r[0] holds the oldest buffered line, line_r[WIN-2] the newest.
   // Indexed by column so each accept rotates one column of the store.
   logic [DW-1:0]         line_r [WIN-1][IMG_W];

   logic [CW-1:0]         col_r;
   logic [RW-1:0]         row_r;
   logic                  valid_r;
   logic                  last_r;
   logic [WIN*WIN*DW-1:0] win_r;

   logic [DW-1:0]         newcol_s [WIN];
   logic [WIN*WIN*DW-1:0] win_next_s;
   logic                  accept_s;
   logic                  qualify_s;
   logic                  col_end_s;
   logic                  row_end_s;

   // The shift window itself is the one-deep output register; it only moves
   // on an accept, and accepts are blocked while a window is held.
   assign pix_ready = !valid_r || win_ready;
   assign win_valid = valid_r;
   assign win_last  = last_r;
   assign win_data  = win_r;

   // Accept qualification and position decode.
   always_comb begin
      accept_s  = pix_valid && pix_ready && !rst;
      col_end_s = (col_r == COL_LAST);
      row_end_s = (row_r == ROW_LAST);
      // Both bounds keep windows from straddling a row or frame boundary.
      qualify_s = (row_r >= ROW_WIN) && (col_r >= COL_WIN);
   end

   // New right-hand column: buffered lines at this column, then the live pixel.
   always_comb begin
      for (int i = 0; i < WIN - 1; i++) begin
         newcol_s[i] = line_r[i][col_r];
      end
      newcol_s[WIN-1] = pix_data;
   end

   // Next window: every row shifts left one word and takes the new column.
   always_comb begin
      win_next_s = win_r;
      for (int i = 0; i < WIN; i++) begin
         for (int j = 0; j < WIN - 1; j++) begin
            win_next_s[DW*(i*WIN+j) +: DW] = win_r[DW*(i*WIN+j+1) +: DW];
         end
         win_next_s[DW*(i*WIN+WIN-1) +: DW] = newcol_s[i];
      end
   end

   // Line store rotation. It is not reset; stale words only reach windows
   // that the validity rule never flags.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int k = 0; k < WIN - 2; k++) begin
            line_r[k][col_r] <= line_r[k+1][col_r];
         end
         line_r[WIN-2][col_r] <= pix_data;
      end
   end

   // Raster position counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r <= '0;
         row_r <= '0;
      end else if (accept_s) begin
         if (col_end_s) begin
            col_r <= '0;
            row_r <= row_end_s ? '0 : (row_r + ROW_ONE);
         end else begin
            col_r <= col_r + COL_ONE;
         end
      end else begin
         col_r <= col_r;
         row_r <= row_r;
      end
   end

   // Output window register, valid and last flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_r   <= '0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
      end else if (accept_s) begin
         win_r   <= win_next_s;
         valid_r <= qualify_s;
         last_r  <= qualify_s && row_end_s && col_end_s;
      end else if (win_ready) begin
         valid_r <= 1'b0;
         last_r  <= 1'b0;
      end else begin
         valid_r <= valid_r;
         last_r  <= last_r;
      end
   end

endmodule

// File: tb/tb_window_linebuffer.sv
module tb_window_linebuffer;

   localparam int DW    = 32;
   localparam int WIN   = 9;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int NW    = WIN * WIN;
   localparam int FRAME = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst;
   logic              pix_valid;
   logic [DW-1:0]     pix_data;
   logic              pix_ready;
   logic              win_valid;
   logic [NW*DW-1:0]  win_data;
   logic              win_last;
   logic              win_ready;

   always #5 clk = ~clk;

   window_linebuffer #(.DW(DW), .WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_ready (pix_ready),
      .win_valid (win_valid),
      .win_data  (win_data),
      .win_last  (win_last),
      .win_ready (win_ready)
   );

   typedef struct {
      logic [NW*DW-1:0] data;
      logic             last;
      int               base;
   } win_t;

   win_t          exp_q[$];
   logic [DW-1:0] hist [IMG_H][IMG_W];
   int            mr = 0;
   int            mc = 0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            hs_count = 0;
   int            lit_base = -1;
   bit            checking = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint word(input logic [NW*DW-1:0] d, input int k);
      return longint'(d[DW*k +: DW]);
   endfunction

   // Reference model: remember the frame, emit a window whenever the
   // accepted pixel is the bottom-right of a full in-frame window.
   task automatic model_accept(input logic [DW-1:0] d);
      win_t w;
      hist[mr][mc] = d;
      if (mr >= WIN - 1 && mc >= WIN - 1) begin
         for (int i = 0; i < WIN; i++)
            for (int j = 0; j < WIN; j++)
               w.data[DW*(i*WIN+j) +: DW] = hist[mr-WIN+1+i][mc-WIN+1+j];
         w.last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
         w.base = lit_base;
         exp_q.push_back(w);
      end
      if (mc == IMG_W - 1) begin
         mc = 0;
         mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end else begin
         mc = mc + 1;
      end
   endtask

   // Compare process, mid-cycle.
   always @(negedge clk) begin
      bit ev;
      if (checking) begin
         ev = (exp_q.size() != 0);
         check("win_valid", win_valid, ev);
         check("pix_ready", pix_ready, (!ev || win_ready));
         if (ev) begin
            n_checks++;
            if (win_data !== exp_q[0].data) begin
               n_fail++;
               for (int k = 0; k < NW; k++) begin
                  if (win_data[DW*k +: DW] !== exp_q[0].data[DW*k +: DW]) begin
                     $display("FAIL win_data word %0d: got %0d, expected %0d (t=%0t)",
                              k, word(win_data, k), word(exp_q[0].data, k), $time);
                     break;
                  end
               end
            end
            check("win_last", win_last, exp_q[0].last);
         end
         if (rst) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
            hs_count = 0;
         end else begin
            if (ev && win_ready) begin
               // Hand-computed ramp expectations pinning the model.
               if (exp_q[0].base >= 0) begin
                  if (hs_count == 0) begin
                     check("first_win_word0", word(win_data, 0), exp_q[0].base);
                     check("first_win_word80", word(win_data, 80), exp_q[0].base + 232);
                  end
                  if (hs_count == 20)
                     check("row9_col8_word0", word(win_data, 0), exp_q[0].base + 28);
                  if (hs_count == 399) begin
                     check("last_win_word80", word(win_data, 80), exp_q[0].base + 783);
                     check("last_win_flag", win_last, 1);
                  end
               end
               if (exp_q[0].last) begin
                  check("windows_per_frame", hs_count + 1, 400);
                  hs_count = 0;
               end else begin
                  hs_count++;
               end
               void'(exp_q.pop_front());
            end
            if (pix_valid && (!ev || win_ready))
               model_accept(pix_data);
         end
      end
   end

   // Feed npix pixels in raster order. mode 0: ramp base+index, mode 1: random.
   task automatic run_pixels(input int npix, input int mode, input int base,
                             input int vpct, input int rpct, input bit do_hold);
      int            p = 0;
      int            cyc = 0;
      int            holdleft = 0;
      bit            held = 1'b0;
      bit            acc;
      logic [DW-1:0] cur;
      lit_base = (mode == 0) ? base : -1;
      cur = (mode == 0) ? 32'(base) : $urandom;
      while (p < npix && cyc < 20000) begin
         pix_valid = ($urandom_range(99) < vpct);
         pix_data  = cur;
         if (do_hold && !held && win_valid) begin
            holdleft = 5;
            held = 1'b1;
         end
         if (holdleft > 0) begin
            win_ready = 1'b0;
            holdleft--;
         end else begin
            win_ready = ($urandom_range(99) < rpct);
         end
         @(negedge clk);
         acc = pix_valid && pix_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            p++;
            cur = (mode == 0) ? 32'(base + p) : $urandom;
         end
      end
      if (p < npix)
         check("stimulus_timeout", p, npix);
   endtask

   initial begin
      rst = 1'b1;
      pix_valid = 1'b0;
      pix_data = '0;
      win_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_win_valid", win_valid, 0);
      check("reset_win_last", win_last, 0);
      check("reset_pix_ready", pix_ready, 1);
      check("reset_win_data_zero", (win_data == '0), 1);
      checking = 1'b1;
      @(posedge clk);
      #1;

      // Ramp frame at full throughput.
      run_pixels(FRAME, 0, 0, 100, 100, 1'b0);
      // Back-to-back offset ramp with a 5-cycle stall and random ready.
      run_pixels(FRAME, 0, 1000, 80, 70, 1'b1);
      // Random data, random handshakes.
      run_pixels(FRAME, 1, 0, 70, 60, 1'b1);
      // Partial frame then reset mid-frame.
      run_pixels(500, 0, 0, 100, 100, 1'b0);
      rst = 1'b1;
      pix_valid = 1'b0;
      win_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_win_valid", win_valid, 0);
      @(posedge clk);
      #1;
      // Fresh frame after reset.
      run_pixels(FRAME, 0, 0, 100, 100, 1'b0);

      pix_valid = 1'b0;
      win_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("drain_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
